// File: rtl/player_action_encoder.sv
// player_action_encoder
//
// Per-player button front end. It turns six raw, bouncing action buttons into
// a one-hot action word that the game logic samples once per game tick.
// Pipeline: 2-flop synchronizer -> per-bit debounce -> rising-edge press
// detect -> lowest-index arbitration -> issue FSM with tick-counted cooldown.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-low
//   btn_raw[5:0] : raw buttons, active-high, asynchronous to clock
//   tick         : one-cycle game-tick strobe
//   action[5:0]  : one-hot action word, 0 = no action
//   action_valid : high exactly while action is non-zero
//   busy         : high while the FSM is not IDLE
//   dropped      : one-cycle registered pulse when a detected press is discarded
//   fsm_state    : current FSM state (IDLE=0, PENDING=1, ISSUED=2, COOLDOWN=3)
//
// Output qualifier: action is meaningful only while action_valid is high, and
// action_valid is high exactly when action is non-zero. There is no ready:
// the consumer samples on its tick, and the word is held for one full tick
// interval so that one sample is guaranteed to see it.

module player_action_encoder #(
  parameter int DEBOUNCE_MAX   = 50000,
  parameter int DEBOUNCE_W     = 16,
  parameter int COOLDOWN_TICKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] btn_raw,
  input  logic       tick,
  output logic [5:0] action,
  output logic       action_valid,
  output logic       busy,
  output logic       dropped,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    ISSUED   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // A cooldown of 0 still needs a legal one-bit counter.
  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_MAX - 1);
  localparam logic [CW-1:0]         CD_LOAD = CW'(COOLDOWN_TICKS);

  logic [5:0]            sync1;
  logic [5:0]            sync2;
  logic [5:0]            stable;
  logic [5:0]            stable_d;
  logic [DEBOUNCE_W-1:0] db_cnt [6];

  logic [5:0] press;
  logic [5:0] winner;
  logic [5:0] losers;

  state_t        state, state_n;
  logic [5:0]    pending, pending_n;
  logic [CW-1:0] cd_cnt, cd_cnt_n;
  logic [5:0]    action_n;
  logic          action_valid_n;
  logic          dropped_n;

  // Synchronizer and debounce. A bit's count only grows while the
  // synchronized level disagrees with the accepted level; any agreement
  // (a bounce back) restarts it from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 6; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edges of the debounced level only; a held button yields one press.
  assign press  = stable & ~stable_d;
  // Two's-complement trick isolates the lowest set bit.
  assign winner = press & (~press + 6'd1);
  assign losers = press & ~winner;

  always_comb begin
    state_n        = state;
    pending_n      = pending;
    cd_cnt_n       = cd_cnt;
    action_n       = action;
    action_valid_n = action_valid;
    dropped_n      = 1'b0;
    case (state)
      IDLE: begin
        // A tick in the capture cycle is deliberately ignored; the press
        // waits for the next tick so it is held for a full interval.
        if (|press) begin
          pending_n = winner;
          dropped_n = |losers;
          state_n   = PENDING;
        end
      end
      PENDING: begin
        dropped_n = |press;
        if (tick) begin
          action_n       = pending;
          action_valid_n = 1'b1;
          pending_n      = '0;
          state_n        = ISSUED;
        end
      end
      ISSUED: begin
        dropped_n = |press;
        if (tick) begin
          action_n       = '0;
          action_valid_n = 1'b0;
          if (COOLDOWN_TICKS == 0) begin
            state_n = IDLE;
          end else begin
            cd_cnt_n = CD_LOAD;
            state_n  = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        dropped_n = |press;
        if (tick) begin
          if (cd_cnt <= 1) begin
            cd_cnt_n = '0;
            state_n  = IDLE;
          end else begin
            cd_cnt_n = cd_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pending      <= '0;
      cd_cnt       <= '0;
      action       <= '0;
      action_valid <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      state        <= state_n;
      pending      <= pending_n;
      cd_cnt       <= cd_cnt_n;
      action       <= action_n;
      action_valid <= action_valid_n;
      dropped      <= dropped_n;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_player_action_encoder.sv
// Bench for player_action_encoder. Two instances with DEBOUNCE_MAX=4:
// dut0 uses a 2-tick cooldown, dut1 uses no cooldown. Both share a free
// running tick every TP cycles. Expected actions are queued when a press is
// driven and popped by a negedge monitor when action rises.

module tb_player_action_encoder;

  localparam int TP  = 20;
  localparam int DBM = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst0, rst1, tick;
  logic [5:0] btn0, btn1, act0, act1;
  logic       av0, av1, busy0, busy1, drop0, drop1;
  logic [1:0] st0, st1;

  player_action_encoder #(.DEBOUNCE_MAX(DBM), .DEBOUNCE_W(8), .COOLDOWN_TICKS(2)) dut0 (
    .clock(clock), .reset(rst0), .btn_raw(btn0), .tick(tick),
    .action(act0), .action_valid(av0), .busy(busy0), .dropped(drop0), .fsm_state(st0)
  );

  player_action_encoder #(.DEBOUNCE_MAX(DBM), .DEBOUNCE_W(8), .COOLDOWN_TICKS(0)) dut1 (
    .clock(clock), .reset(rst1), .btn_raw(btn1), .tick(tick),
    .action(act1), .action_valid(av1), .busy(busy1), .dropped(drop1), .fsm_state(st1)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  logic [5:0] prev_act [2];
  int         act_len  [2];
  int         cool_len [2];
  bit         in_cool  [2];
  int         drop_cnt [2];
  int         exp_cool [2];

  typedef struct {
    logic [5:0] pattern;
    int         hold;
    logic [5:0] exp_act;
    int         exp_drops;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return av0;
      1:       return busy0;
      2:       return av1;
      default: return busy1;
    endcase
  endfunction

  task automatic set_btn(input int d, input logic [5:0] v);
    if (d == 0) btn0 = v;
    else        btn1 = v;
  endtask

  task automatic push_exp(input int d, input logic [5:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic wait_until(input int which, input logic val, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (get_sig(which) == val) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  // Called right after the level is driven at a negedge; the next posedge is
  // the first sample k. Capture must land on edge k+2+DBM, not earlier.
  task automatic timing_check(input int d, input string name);
    repeat (DBM + 2) @(posedge clock);
    #1;
    check({name, "_early"}, {31'd0, get_sig(2 * d + 1)}, 32'd0);
    @(posedge clock);
    #1;
    check({name, "_capture"}, {31'd0, get_sig(2 * d + 1)}, 32'd1);
  endtask

  task automatic press_and_check(input int d, input logic [5:0] pattern, input int hold,
                                 input logic [5:0] exp_act, input int exp_drops,
                                 input string name);
    int d_start;
    d_start = drop_cnt[d];
    repeat ($urandom_range(0, TP - 1)) @(negedge clock);
    if (exp_act != 0) push_exp(d, exp_act);
    @(negedge clock);
    set_btn(d, pattern);
    timing_check(d, name);
    repeat (hold) @(negedge clock);
    set_btn(d, 6'd0);
    wait_until(2 * d + 1, 1'b0, 300, {name, "_idle"});
    repeat (10) @(negedge clock);
    check({name, "_drops"}, drop_cnt[d] - d_start, exp_drops);
    check({name, "_q_empty"}, (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic mon_step(input int d, input logic rst, input logic [5:0] a, input logic v,
                          input logic b, input logic dr);
    logic [5:0] e;
    if (!rst) begin
      prev_act[d] = '0;
      act_len[d]  = 0;
      in_cool[d]  = 1'b0;
      cool_len[d] = 0;
    end else begin
      check($sformatf("valid_flag%0d", d), {31'd0, v}, {31'd0, (a != 0)});
      check($sformatf("onehot%0d", d), {31'd0, $onehot0(a)}, 32'd1);
      if (dr) drop_cnt[d]++;
      if (a != 0) begin
        if (prev_act[d] == 0) begin
          if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            check($sformatf("unexpected_action%0d", d), {26'd0, a}, 32'd0);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("action_value%0d", d), {26'd0, a}, {26'd0, e});
          end
          act_len[d] = 1;
        end else begin
          check($sformatf("action_hold%0d", d), {26'd0, a}, {26'd0, prev_act[d]});
          act_len[d]++;
        end
      end else if (prev_act[d] != 0) begin
        check($sformatf("action_len%0d", d), act_len[d], TP);
        in_cool[d]  = 1'b1;
        cool_len[d] = 0;
      end
      if (in_cool[d]) begin
        if (b) begin
          cool_len[d]++;
        end else begin
          check($sformatf("cooldown_len%0d", d), cool_len[d], exp_cool[d]);
          in_cool[d] = 1'b0;
        end
      end
      prev_act[d] = a;
    end
  endtask

  always @(negedge clock) begin
    mon_step(0, rst0, act0, av0, busy0, drop0);
    mon_step(1, rst1, act1, av1, busy1, drop1);
  end

  // Free-running game tick.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (TP - 1) @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_start;
    for (int d = 0; d < 2; d++) begin
      prev_act[d] = '0;
      act_len[d]  = 0;
      cool_len[d] = 0;
      in_cool[d]  = 1'b0;
      drop_cnt[d] = 0;
    end
    exp_cool[0] = 2 * TP;
    exp_cool[1] = 0;

    vecs[0] = '{6'b000100,  10, 6'b000100, 0};
    vecs[1] = '{6'b010010,  10, 6'b000010, 1};
    vecs[2] = '{6'b100000, 200, 6'b100000, 0};
    vecs[3] = '{6'b111111,  10, 6'b000001, 1};
    vecs[4] = '{6'b101000,  12, 6'b001000, 1};
    vecs[5] = '{6'b010000,  30, 6'b010000, 0};

    rst0 = 1'b0;
    rst1 = 1'b0;
    btn0 = '0;
    btn1 = '0;
    repeat (3) @(negedge clock);
    check("rst_action0", {26'd0, act0}, 32'd0);
    check("rst_valid0", {31'd0, av0}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_dropped0", {31'd0, drop0}, 32'd0);
    check("rst_action1", {26'd0, act1}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (5) @(negedge clock);

    // Single presses and simultaneous presses, cooldown of 2 ticks.
    for (int i = 0; i < 6; i++) begin
      press_and_check(0, vecs[i].pattern, vecs[i].hold, vecs[i].exp_act,
                      vecs[i].exp_drops, $sformatf("vec%0d", i));
    end

    // Bounce on bit 0: every high run is shorter than DBM, so nothing is
    // accepted until the final steady level.
    for (int i = 0; i < 8; i++) begin
      btn0[0] = ~btn0[0];
      repeat ($urandom_range(1, DBM - 1)) @(negedge clock);
    end
    btn0 = '0;
    repeat (2) @(negedge clock);
    check("bounce_no_capture", {31'd0, busy0}, 32'd0);
    press_and_check(0, 6'b000001, 10, 6'b000001, 0, "bounce_final");

    // Presses during ISSUED and during COOLDOWN are dropped.
    d_start = drop_cnt[0];
    exp_q0.push_back(6'b000010);
    @(negedge clock);
    btn0 = 6'b000010;
    timing_check(0, "issue_b1");
    repeat (5) @(negedge clock);
    btn0 = '0;
    wait_until(0, 1'b1, 100, "wait_issued");
    btn0 = 6'b001000;
    repeat (8) @(negedge clock);
    btn0 = '0;
    wait_until(0, 1'b0, 100, "wait_cleared");
    check("drop_in_issued", drop_cnt[0] - d_start, 1);
    check("in_cooldown", {30'd0, st0}, 32'd3);
    btn0 = 6'b001000;
    repeat (8) @(negedge clock);
    btn0 = '0;
    wait_until(1, 1'b0, 200, "wait_cool_idle");
    check("drop_in_cooldown", drop_cnt[0] - d_start, 2);
    press_and_check(0, 6'b001000, 10, 6'b001000, 0, "after_cooldown");

    // No cooldown: ISSUED returns straight to IDLE on the clearing tick.
    exp_q1.push_back(6'b000001);
    @(negedge clock);
    btn1 = 6'b000001;
    timing_check(1, "nocd");
    wait_until(2, 1'b1, 100, "nocd_issue");
    wait_until(2, 1'b0, 100, "nocd_clear");
    check("nocd_idle_on_clear", {31'd0, busy1}, 32'd0);
    btn1 = '0;
    repeat (10) @(negedge clock);

    // Reset in the middle of ISSUED with the button still held.
    exp_q1.push_back(6'b000001);
    @(negedge clock);
    btn1 = 6'b000001;
    timing_check(1, "pre_reset");
    wait_until(2, 1'b1, 100, "pre_reset_issue");
    repeat (5) @(negedge clock);
    #2;
    rst1 = 1'b0;
    #1;
    check("async_rst_action", {26'd0, act1}, 32'd0);
    check("async_rst_valid", {31'd0, av1}, 32'd0);
    check("async_rst_busy", {31'd0, busy1}, 32'd0);
    repeat (3) @(negedge clock);
    exp_q1.push_back(6'b000001);
    rst1 = 1'b1;
    timing_check(1, "post_reset");
    wait_until(2, 1'b1, 100, "post_reset_issue");
    wait_until(2, 1'b0, 100, "post_reset_clear");
    btn1 = '0;
    repeat (10) @(negedge clock);

    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
